regfile_sb: RTL and testbench

Parametrised multi-read-port register file with write-through bypass and a per-register pending-write scoreboard. It replaces the single-read-port register file in the npc core datapath. Decode reads N operands per cycle, marks its destination register pending at issue, and writeback clears the mark. The hazard logic uses the busy flags and pending count to stall.

---
 rtl/regfile_sb.sv | 129 ++++++++++++
 tb/tb_regfile_sb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Multi-read-port register file with write-through bypass and a
//            per-register pending-write scoreboard with a pending count.
// Revision : 1.0
// ============================================================================
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          iss_valid,
  input  logic [ADDR_WIDTH-1:0]         iss_addr,
  input  logic                          flush,
  input  logic [NREAD*ADDR_WIDTH-1:0]   raddr,
  output logic [NREAD*DATA_WIDTH-1:0]   rdata,
  output logic [NREAD-1:0]              rbusy,
  output logic [ADDR_WIDTH:0]           pend_cnt
);

  localparam int               c_NREGS   = 2 ** ADDR_WIDTH;
  localparam bit               c_BYPASS  = (BYPASS != 0);
  localparam bit               c_ZERO    = (ZERO_REG != 0);
  localparam logic [ADDR_WIDTH:0] c_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_rf [c_NREGS];
  logic [c_NREGS-1:0]    r_busy;
  logic [c_NREGS-1:0]    w_busy_nxt;
  logic [ADDR_WIDTH:0]   r_pend_cnt;
  logic [ADDR_WIDTH:0]   w_pend_nxt;
  logic                  w_wr_ok;
  logic                  w_iss_ok;
  logic                  w_cnt_inc;
  logic                  w_cnt_dec;

  // Flush drops a same-cycle issue; register 0 is inert when hardwired.
  assign w_wr_ok  = wen && !(c_ZERO && (waddr == '0));
  assign w_iss_ok = iss_valid && !flush && !(c_ZERO && (iss_addr == '0));

  // Issue is applied after the write clear so a colliding producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[waddr] = 1'b0;
    end
    if (w_iss_ok) begin
      w_busy_nxt[iss_addr] = 1'b1;
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
  end

  always_comb begin
    w_cnt_inc  = w_iss_ok && !r_busy[iss_addr];
    w_cnt_dec  = w_wr_ok && r_busy[waddr] && !(w_iss_ok && (iss_addr == waddr));
    w_pend_nxt = r_pend_cnt;
    if (flush) begin
      w_pend_nxt = '0;
    end else if (w_cnt_inc && !w_cnt_dec) begin
      w_pend_nxt = r_pend_cnt + c_CNT_ONE;
    end else if (w_cnt_dec && !w_cnt_inc) begin
      w_pend_nxt = r_pend_cnt - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_pend_nxt;
    end
  end

  generate
    for (genvar k = 0; k < c_NREGS; k++) begin : g_reg
      localparam logic [ADDR_WIDTH-1:0] c_IDX = ADDR_WIDTH'(k);
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rf[k] <= '0;
        end else if (w_wr_ok && (waddr == c_IDX)) begin
          r_rf[k] <= wdata;
        end
      end
    end
  endgenerate

  generate
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      logic [DATA_WIDTH-1:0] w_rd;
      logic                  w_rb;

      assign w_ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

      // Priority: hardwired zero, then bypass, then stored state.
      always_comb begin
        w_rd = r_rf[w_ra];
        w_rb = r_busy[w_ra];
        if (c_BYPASS && wen && (waddr == w_ra)) begin
          w_rd = wdata;
          w_rb = 1'b0;
        end
        if (c_ZERO && (w_ra == '0)) begin
          w_rd = '0;
          w_rb = 1'b0;
        end
      end

      assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_rd;
      assign rbusy[i]                          = w_rb;
    end
  endgenerate

  assign pend_cnt = r_pend_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Scoreboard bench for regfile_sb: directed vectors on the default
//            configuration, model-driven mix on NREAD=3/BYPASS=0/ZERO_REG=0.
// Revision : 1.0
// ============================================================================
module tb_regfile_sb;

  typedef struct {
    int          dut;
    int          tag;
    logic [63:0] rd;
    logic [3:0]  rb;
    logic [6:0]  pc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_kick = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance
  logic        rst, wen, iss_valid, flush;
  logic [4:0]  waddr, iss_addr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [5:0]  pend_cnt;

  regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .pend_cnt(pend_cnt)
  );

  // Small instance for the model-driven mix
  logic        rst1, wen1, iss1, flush1;
  logic [2:0]  waddr1, iss_addr1;
  logic [15:0] wdata1;
  logic [8:0]  raddr1;
  logic [47:0] rdata1;
  logic [2:0]  rbusy1;
  logic [3:0]  pend1;

  regfile_sb #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .NREAD(3), .BYPASS(0), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst(rst1), .wen(wen1), .waddr(waddr1), .wdata(wdata1),
    .iss_valid(iss1), .iss_addr(iss_addr1), .flush(flush1),
    .raddr(raddr1), .rdata(rdata1), .rbusy(rbusy1), .pend_cnt(pend1)
  );

  // Monitor: drains the expectation queue each negedge or on an explicit kick.
  initial begin
    exp_t        e;
    logic [63:0] ard;
    logic [3:0]  arb;
    logic [6:0]  apc;
    forever begin
      @(negedge clk or posedge mon_kick);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut == 0) begin
          ard = rdata;
          arb = {2'b00, rbusy};
          apc = {1'b0, pend_cnt};
        end else begin
          ard = {16'h0, rdata1};
          arb = {1'b0, rbusy1};
          apc = {3'b000, pend1};
        end
        checks++;
        if (ard !== e.rd || arb !== e.rb || apc !== e.pc) begin
          failures++;
          $display("FAIL dut%0d step %0d: got rdata=%h rbusy=%b pend_cnt=%0d, required rdata=%h rbusy=%b pend_cnt=%0d",
                   e.dut, e.tag, ard, arb, apc, e.rd, e.rb, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic iv, input logic [4:0] ia, input logic fl,
                      input logic [4:0] r0, input logic [4:0] r1);
    wen = we; waddr = wa; wdata = wd;
    iss_valid = iv; iss_addr = ia; flush = fl;
    raddr = {r1, r0};
  endtask

  task automatic exp0(input int tag, input logic [31:0] d0, input logic [31:0] d1,
                      input logic b0, input logic b1, input int pc);
    exp_t e;
    e.dut = 0; e.tag = tag;
    e.rd  = {d1, d0};
    e.rb  = {2'b00, b1, b0};
    e.pc  = 7'(pc);
    q.push_back(e);
  endtask

  // Hand-known contents of dut0 before the saturation sweep
  function automatic logic [31:0] val0(input int r);
    case (r)
      3:       return 32'hA5;
      7:       return 32'h77;
      8:       return 32'h88;
      9:       return 32'h99;
      default: return 32'h0;
    endcase
  endfunction

  logic [15:0] m_rf   [8];
  logic [7:0]  m_busy;

  initial begin
    exp_t e;
    int   ra;
    rst = 1'b1; rst1 = 1'b1;
    drv0(0, 0, 0, 0, 0, 0, 0, 0);
    wen1 = 0; waddr1 = 0; wdata1 = 0; iss1 = 0; iss_addr1 = 0; flush1 = 0; raddr1 = 0;
    tick();

    // Reset / zero register
    drv0(1, 0, 32'hDEADBEEF, 1, 5, 0, 0, 5); exp0(0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0;
    drv0(0, 0, 0, 0, 0, 0, 0, 5);            exp0(1, 0, 0, 0, 0, 0); tick();

    // Bypass
    drv0(1, 8, 32'h88, 0, 0, 0, 8, 7);       exp0(2, 32'h88, 0, 0, 0, 0); tick();
    drv0(1, 7, 32'h12345678, 0, 0, 0, 7, 8); exp0(3, 32'h12345678, 32'h88, 0, 0, 0); tick();

    // Scoreboard
    drv0(0, 0, 0, 1, 3, 0, 3, 7);            exp0(4, 0, 32'h12345678, 0, 0, 0); tick();
    drv0(0, 0, 0, 1, 4, 0, 3, 4);            exp0(5, 0, 0, 1, 0, 1); tick();
    drv0(1, 3, 32'hA5, 0, 0, 0, 3, 4);       exp0(6, 32'hA5, 0, 0, 1, 2); tick();
    drv0(0, 0, 0, 0, 0, 0, 3, 4);            exp0(7, 32'hA5, 0, 0, 1, 1); tick();

    // Collision, write to non-busy, re-issue, flush
    drv0(1, 9, 32'h99, 1, 9, 0, 9, 4);       exp0(8, 32'h99, 0, 0, 1, 1); tick();
    drv0(0, 0, 0, 0, 0, 0, 9, 4);            exp0(9, 32'h99, 0, 1, 1, 2); tick();
    drv0(1, 7, 32'h77, 0, 0, 0, 7, 9);       exp0(10, 32'h77, 32'h99, 0, 1, 2); tick();
    drv0(0, 0, 0, 1, 9, 0, 7, 9);            exp0(11, 32'h77, 32'h99, 0, 1, 2); tick();
    drv0(0, 0, 0, 1, 10, 1, 10, 4);          exp0(12, 0, 0, 0, 1, 2); tick();
    drv0(0, 0, 0, 0, 0, 0, 10, 9);           exp0(13, 0, 32'h99, 0, 0, 0); tick();

    // Zero register ignores write and issue
    drv0(1, 0, 32'hFFFF, 1, 0, 0, 0, 0);     exp0(14, 0, 0, 0, 0, 0); tick();
    drv0(0, 0, 0, 0, 0, 0, 0, 0);            exp0(15, 0, 0, 0, 0, 0); tick();

    // Saturation
    for (int i = 1; i < 32; i++) begin
      drv0(0, 0, 0, 1, 5'(i), 0, 5'(i), 5'(i - 1));
      exp0(100 + i, val0(i), val0(i - 1), 1'b0, (i > 1), i - 1);
      tick();
    end
    drv0(0, 0, 0, 0, 0, 0, 31, 3);           exp0(200, 0, 32'hA5, 1, 1, 31);

    // Asynchronous reset between edges
    #6;
    rst = 1'b1;
    drv0(0, 0, 0, 1, 12, 0, 3, 12);
    #1;
    exp0(201, 0, 0, 0, 0, 0);
    mon_kick = 1'b1;
    #1;
    mon_kick = 1'b0;
    tick();
    rst = 1'b0;
    drv0(0, 0, 0, 0, 0, 0, 3, 12);           exp0(202, 0, 0, 0, 0, 0); tick();

    // Model-driven mix on the second instance
    wen1 = 1'b1; waddr1 = 3'd2; wdata1 = 16'hBEEF; iss1 = 1'b1; iss_addr1 = 3'd2;
    raddr1 = {3'd2, 3'd1, 3'd0};
    e.dut = 1; e.tag = 300; e.rd = 64'h0; e.rb = 4'h0; e.pc = 7'h0;
    q.push_back(e);
    tick();
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) m_rf[k] = 16'h0;
    m_busy = 8'h0;
    for (int n = 0; n < 300; n++) begin
      wen1      = ($urandom_range(1, 0) == 1);
      waddr1    = 3'($urandom);
      wdata1    = 16'($urandom);
      iss1      = ($urandom_range(4, 0) < 2);
      iss_addr1 = ($urandom_range(3, 0) == 0) ? waddr1 : 3'($urandom);
      flush1    = ($urandom_range(11, 0) == 0);
      raddr1    = 9'($urandom);
      if ($urandom_range(2, 0) == 0) raddr1[2:0] = waddr1;
      e.dut = 1; e.tag = 400 + n; e.rd = 64'h0; e.rb = 4'h0;
      e.pc  = 7'($countones(m_busy));
      for (int p = 0; p < 3; p++) begin
        ra = int'(raddr1[p*3 +: 3]);
        e.rd[p*16 +: 16] = m_rf[ra];
        e.rb[p]          = m_busy[ra];
      end
      q.push_back(e);
      if (wen1) begin
        m_rf[waddr1]   = wdata1;
        m_busy[waddr1] = 1'b0;
      end
      if (flush1) m_busy = 8'h0;
      else if (iss1) m_busy[iss_addr1] = 1'b1;
      tick();
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending entries, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
